// File: rtl/leaf_pkt_pkg.sv
// BFT packet layout shared by the leaf-side stream unpacker.
package leaf_pkt_pkg;

  localparam int PKT_W       = 49;
  localparam int VALID_B     = 48;
  localparam int DEST_LSB    = 43;
  localparam int DEST_W      = 5;
  localparam int PORT_LSB    = 39;
  localparam int PORT_W      = 4;
  localparam int RSVD_LSB    = 32;
  localparam int RSVD_W      = 7;
  localparam int PAY_LSB     = 0;
  localparam int PAY_W       = 32;

  // Config packets travel on port 0; payload carries target port index and source address.
  localparam int CFG_PORT    = 0;
  localparam int CFG_IDX_LSB = 8;
  localparam int CFG_IDX_W   = 4;
  localparam int CFG_SRC_LSB = 0;

  typedef logic [PKT_W-1:0] pkt_t;

  function automatic pkt_t pack_credit(input logic [DEST_W-1:0] dest,
                                       input logic [PORT_W-1:0] port,
                                       input logic [PAY_W-1:0]  count);
    pkt_t pkt;
    pkt                          = '0;
    pkt[VALID_B]                 = 1'b1;
    pkt[DEST_LSB +: DEST_W]      = dest;
    pkt[PORT_LSB +: PORT_W]      = port;
    pkt[PAY_LSB +: PAY_W]        = count;
    return pkt;
  endfunction

endpackage

// File: rtl/leaf_port_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is taken when a pop
// frees a slot in the same cycle.
module leaf_port_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/leaf_stream_unpacker.sv
// Demuxes BFT packets into per-port FWFT streams and returns round-robin credit packets
// to each stream's upstream leaf.
module leaf_stream_unpacker
  import leaf_pkt_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int CREDIT_BATCH = 4,
  parameter int DATA_W       = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ap_start,
  input  logic                        resend,
  input  logic [PKT_W-1:0]            din_leaf_bft2interface,
  output logic [PKT_W-1:0]            dout_leaf_interface2bft,
  output logic [NUM_PORTS*DATA_W-1:0] m_tdata,
  output logic [NUM_PORTS-1:0]        m_tvalid,
  input  logic [NUM_PORTS-1:0]        m_tready,
  output logic [NUM_PORTS-1:0]        overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int RR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] BATCH   = CNT_W'(CREDIT_BATCH);

  logic              pkt_v;
  logic [PORT_W-1:0] pkt_port;
  logic [PAY_W-1:0]  pkt_pay;
  logic              unused_fields;

  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] sel_hit;
  logic [NUM_PORTS-1:0] cfg_pend;
  logic [CNT_W-1:0]     pend     [NUM_PORTS];
  logic [DEST_W-1:0]    src_addr [NUM_PORTS];

  logic            flush_req;
  logic            found;
  logic [RR_W-1:0] sel;
  logic [RR_W-1:0] rr_ptr;

  assign pkt_v         = din_leaf_bft2interface[VALID_B] & ap_start;
  assign pkt_port      = din_leaf_bft2interface[PORT_LSB +: PORT_W];
  assign pkt_pay       = din_leaf_bft2interface[PAY_LSB +: PAY_W];
  assign unused_fields = ^{din_leaf_bft2interface[DEST_LSB +: DEST_W],
                           din_leaf_bft2interface[RSVD_LSB +: RSVD_W]};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic              push;
    logic              full;
    logic              empty;
    logic              cfg_hit;
    logic              ovf_q;
    logic              cfg_q;
    logic [DEST_W-1:0] src_q;
    logic [CNT_W-1:0]  pend_q;

    assign push    = pkt_v && (pkt_port == PORT_W'(p + 1));
    assign cfg_hit = pkt_v && (pkt_port == PORT_W'(CFG_PORT)) &&
                     (pkt_pay[CFG_IDX_LSB +: CFG_IDX_W] == CFG_IDX_W'(p + 1));

    leaf_port_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop[p]),
      .din   (pkt_pay[DATA_W-1:0]),
      .dout  (m_tdata[p*DATA_W +: DATA_W]),
      .full  (full),
      .empty (empty)
    );

    assign m_tvalid[p] = ~empty;
    assign pop[p]      = m_tvalid[p] & m_tready[p];
    assign overflow[p] = ovf_q;
    assign src_addr[p] = src_q;
    assign pend[p]     = pend_q;
    assign cfg_pend[p] = cfg_q && (pend_q != '0);
    assign elig[p]     = cfg_q && ((pend_q >= BATCH) || (flush_req && (pend_q != '0)));
    assign sel_hit[p]  = found && (sel == RR_W'(p));

    // Sticky drop flag: push to a full FIFO with no pop to make room.
    always_ff @(posedge clk) begin
      if (!reset)                        ovf_q <= 1'b0;
      else if (push && full && !pop[p])  ovf_q <= 1'b1;
    end

    // Upstream source address for this port's credits, learned from config packets.
    always_ff @(posedge clk) begin
      if (!reset) begin
        cfg_q <= 1'b0;
        src_q <= '0;
      end else if (cfg_hit) begin
        cfg_q <= 1'b1;
        src_q <= pkt_pay[CFG_SRC_LSB +: DEST_W];
      end
    end

    // Pending credit count: a pop coinciding with emission starts the next batch at 1.
    always_ff @(posedge clk) begin
      if (!reset)                             pend_q <= '0;
      else if (sel_hit[p])                    pend_q <= pop[p] ? CNT_W'(1) : '0;
      else if (pop[p] && (pend_q != CNT_MAX)) pend_q <= pend_q + 1'b1;
    end
  end

  // Round-robin pick of the first eligible port at or after the pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (!found && elig[RR_W'((32'(rr_ptr) + k) % NUM_PORTS)]) begin
        found = 1'b1;
        sel   = RR_W'((32'(rr_ptr) + k) % NUM_PORTS);
      end
    end
  end

  // Registered credit packet output and pointer advance past the served port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_leaf_interface2bft <= '0;
      rr_ptr                  <= '0;
    end else if (found) begin
      dout_leaf_interface2bft <= pack_credit(src_addr[sel], PORT_W'(sel) + PORT_W'(1),
                                             PAY_W'(pend[sel]));
      rr_ptr                  <= (sel == RR_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
    end else begin
      dout_leaf_interface2bft <= '0;
    end
  end

  // Flush request: held until no configured port has credit left to return.
  always_ff @(posedge clk) begin
    if (!reset)          flush_req <= 1'b0;
    else if (flush_req) begin
      if (cfg_pend == '0) flush_req <= 1'b0;
    end else if (resend) flush_req <= 1'b1;
  end

endmodule

// File: tb/tb_leaf_stream_unpacker.sv
// Bench for leaf_stream_unpacker: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_leaf_stream_unpacker;

  localparam int NP   = 4;
  localparam int D    = 16;
  localparam int CB   = 4;
  localparam int DW   = 32;
  localparam int PMAX = 2 * D - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              ap_start;
  logic              resend;
  logic [48:0]       din;
  logic [48:0]       dout;
  logic [NP*DW-1:0]  m_tdata;
  logic [NP-1:0]     m_tvalid;
  logic [NP-1:0]     m_tready;
  logic [NP-1:0]     overflow;

  always #5 clk = ~clk;

  leaf_stream_unpacker #(
    .NUM_PORTS    (NP),
    .FIFO_DEPTH   (D),
    .CREDIT_BATCH (CB),
    .DATA_W       (DW)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .ap_start                (ap_start),
    .resend                  (resend),
    .din_leaf_bft2interface  (din),
    .dout_leaf_interface2bft (dout),
    .m_tdata                 (m_tdata),
    .m_tvalid                (m_tvalid),
    .m_tready                (m_tready),
    .overflow                (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference state: contents of each stream, flags, credit counts, arbiter position.
  logic [31:0] mq [NP][$];
  bit          mov   [NP];
  bit          mcfg  [NP];
  logic [4:0]  msrc  [NP];
  int          mpend [NP];
  int          mrr;
  bit          mflush;
  logic [48:0] mdout;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [48:0] pkt(input int port, input logic [31:0] pay);
    return {1'b1, 5'd0, 4'(port), 7'd0, pay};
  endfunction

  // Advance the model by one clock using the inputs that were present at the edge.
  task automatic model_step();
    bit popv [NP];
    int sel;
    int p;
    int port;
    int idx;
    bit any;
    if (!reset) begin
      for (int i = 0; i < NP; i++) begin
        mq[i].delete();
        mov[i]   = 1'b0;
        mcfg[i]  = 1'b0;
        msrc[i]  = '0;
        mpend[i] = 0;
      end
      mrr    = 0;
      mflush = 1'b0;
      mdout  = '0;
      return;
    end
    for (int i = 0; i < NP; i++) popv[i] = (mq[i].size() > 0) && m_tready[i];
    sel = -1;
    for (int k = 0; k < NP; k++) begin
      p = (mrr + k) % NP;
      if (sel < 0 && mcfg[p] && (mpend[p] >= CB || (mflush && mpend[p] > 0))) sel = p;
    end
    if (sel >= 0) begin
      mdout = {1'b1, msrc[sel], 4'(sel + 1), 7'd0, 32'(mpend[sel])};
      mrr   = (sel + 1) % NP;
    end else begin
      mdout = '0;
    end
    if (mflush) begin
      any = 1'b0;
      for (int i = 0; i < NP; i++) if (mcfg[i] && mpend[i] > 0) any = 1'b1;
      if (!any) mflush = 1'b0;
    end else if (resend) begin
      mflush = 1'b1;
    end
    for (int i = 0; i < NP; i++) begin
      if (i == sel)      mpend[i] = popv[i] ? 1 : 0;
      else if (popv[i])  mpend[i] = (mpend[i] + 1 > PMAX) ? PMAX : mpend[i] + 1;
    end
    for (int i = 0; i < NP; i++) if (popv[i]) void'(mq[i].pop_front());
    if (din[48] && ap_start) begin
      port = int'(din[42:39]);
      if (port == 0) begin
        idx = int'(din[11:8]);
        if (idx >= 1 && idx <= NP) begin
          msrc[idx-1] = din[4:0];
          mcfg[idx-1] = 1'b1;
        end
      end else if (port <= NP) begin
        if (mq[port-1].size() < D) mq[port-1].push_back(din[31:0]);
        else                       mov[port-1] = 1'b1;
      end
    end
  endtask

  // Compare DUT outputs against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NP; p++) begin
        check($sformatf("tvalid[%0d]", p), 64'(m_tvalid[p]), 64'(mq[p].size() > 0));
        if (mq[p].size() > 0)
          check($sformatf("tdata[%0d]", p), 64'(m_tdata[p*DW +: DW]), 64'(mq[p][0]));
        check($sformatf("overflow[%0d]", p), 64'(overflow[p]), 64'(mov[p]));
      end
      check("dout", 64'(dout), 64'(mdout));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    din    = '0;
    resend = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    din   = '0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  logic [48:0] seen [$];
  int          pops;
  logic [31:0] last_pop;

  initial begin
    reset    = 1'b0;
    ap_start = 1'b1;
    resend   = 1'b0;
    din      = '0;
    m_tready = '0;
    do_reset();
    check("reset_tvalid", 64'(m_tvalid), 64'd0);
    check("reset_dout", 64'(dout), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);

    // Config port1 src=5, four packets, drain, one credit of 4.
    din = pkt(0, 32'h0000_0105);
    cyc();
    for (int i = 0; i < 4; i++) begin
      din = pkt(1, 32'hA0 + 32'(i));
      cyc();
    end
    din      = '0;
    m_tready = 4'b0001;
    pops     = 0;
    seen.delete();
    for (int i = 0; i < 10; i++) begin
      if (m_tvalid[0]) begin
        check("t1_order", 64'(m_tdata[31:0]), 64'(32'hA0 + 32'(pops)));
        pops++;
      end
      cyc();
      if (dout != '0) seen.push_back(dout);
    end
    check("t1_pops", 64'(pops), 64'd4);
    check("t1_credits", 64'(seen.size()), 64'd1);
    if (seen.size() > 0) check("t1_credit_pkt", 64'(seen[0]), 64'h1_2880_0000_0004);

    // Overfill port2 with the stream stalled; overflow stays set after draining.
    m_tready = '0;
    for (int i = 0; i < 17; i++) begin
      din = pkt(2, 32'hB00 + 32'(i));
      cyc();
    end
    din = '0;
    check("t2_ovf_set", 64'(overflow[1]), 64'd1);
    m_tready = 4'b0010;
    pops     = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_tvalid[1]) pops++;
      cyc();
    end
    check("t2_buffered", 64'(pops), 64'd16);
    check("t2_ovf_sticky", 64'(overflow[1]), 64'd1);
    m_tready = '0;

    // Full FIFO with simultaneous push and pop accepts the push.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      din = pkt(3, 32'hC00 + 32'(i));
      cyc();
    end
    din      = pkt(3, 32'hCFF);
    m_tready = 4'b0100;
    cyc();
    din      = '0;
    m_tready = '0;
    cyc();
    check("t3_no_ovf", 64'(overflow[2]), 64'd0);
    m_tready = 4'b0100;
    pops     = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_tvalid[2]) begin
        pops++;
        last_pop = m_tdata[2*DW +: DW];
      end
      cyc();
    end
    check("t3_count", 64'(pops), 64'd16);
    check("t3_last", 64'(last_pop), 64'hCFF);
    m_tready = '0;

    // All four ports reach the batch together: credits in order 1..4, twice.
    do_reset();
    for (int p = 0; p < NP; p++) begin
      din = pkt(0, 32'((p + 1) << 8) | 32'(10 + p));
      cyc();
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++)
        for (int p = 0; p < NP; p++) begin
          din = pkt(p + 1, 32'(r * 100 + p * 10 + i));
          cyc();
        end
      din = '0;
      seen.delete();
      for (int i = 0; i < 12; i++) begin
        m_tready = (i < 4) ? 4'hF : 4'h0;
        cyc();
        if (dout != '0) seen.push_back(dout);
      end
      check($sformatf("t4_round%0d_n", r), 64'(seen.size()), 64'd4);
      for (int k = 0; k < seen.size(); k++) begin
        check($sformatf("t4_round%0d_port", r), 64'(seen[k][42:39]), 64'(k + 1));
        check($sformatf("t4_round%0d_cnt", r), 64'(seen[k][31:0]), 64'd4);
      end
    end
    m_tready = '0;

    // Resend flushes a partial batch on a configured port only.
    do_reset();
    din = pkt(0, 32'h0000_0307);
    cyc();
    for (int i = 0; i < 2; i++) begin din = pkt(3, 32'(i)); cyc(); end
    for (int i = 0; i < 3; i++) begin din = pkt(1, 32'(i)); cyc(); end
    din      = '0;
    m_tready = 4'hF;
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (dout != '0) seen.push_back(dout);
    end
    check("t5_no_credit_before", 64'(seen.size()), 64'd0);
    resend = 1'b1;
    cyc();
    resend = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (dout != '0) seen.push_back(dout);
    end
    check("t5_flush_n", 64'(seen.size()), 64'd1);
    if (seen.size() > 0) check("t5_flush_pkt", 64'(seen[0]), 64'h1_3980_0000_0002);
    check("t5_dout_idle", 64'(dout), 64'd0);

    // ap_start low blocks config and data; then reset mid-stream.
    m_tready = '0;
    ap_start = 1'b0;
    din = pkt(0, 32'h0000_0209); cyc();
    din = pkt(2, 32'h1234);      cyc();
    din = pkt(2, 32'h5678);      cyc();
    din = '0;
    cyc();
    check("t6_blocked", 64'(m_tvalid), 64'd0);
    ap_start = 1'b1;
    for (int i = 0; i < 4; i++) begin din = pkt(2, 32'(i)); cyc(); end
    din      = '0;
    m_tready = 4'b0010;
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (dout != '0) seen.push_back(dout);
    end
    check("t6_unconfigured", 64'(seen.size()), 64'd0);
    m_tready = '0;
    for (int i = 0; i < 3; i++) begin din = pkt(1, 32'hD0 + 32'(i)); cyc(); end
    reset = 1'b0;
    din   = pkt(1, 32'hDF);
    cyc();
    check("t6_reset_tvalid", 64'(m_tvalid), 64'd0);
    check("t6_reset_dout", 64'(dout), 64'd0);
    reset = 1'b1;
    din   = '0;
    cyc();

    // Randomized traffic: a congested phase followed by a draining phase.
    for (int i = 0; i < 4000; i++) begin
      int port;
      logic [31:0] pay;
      port = $urandom_range(0, 6);
      pay  = $urandom;
      if (port == 0) pay[11:8] = 4'($urandom_range(0, 5));
      din = {1'($urandom_range(0, 3) != 0), 5'($urandom), 4'(port), 7'd0, pay};
      ap_start = ($urandom_range(0, 9) != 0);
      resend   = ($urandom_range(0, 29) == 0);
      m_tready = 4'($urandom) & ((i < 2000) ? 4'($urandom) : 4'hF);
      reset    = ($urandom_range(0, 999) != 0);
      cyc();
    end
    reset = 1'b1;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
